// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_GROUP_W = 4;

  // Per-group propagate/generate pair feeding the second-level lookahead.
  typedef struct packed {
    logic p;
    logic g;
  } cla_pg_t;

  function automatic int unsigned cla_groups(input int unsigned width);
    return width / CLA_GROUP_W;
  endfunction

  function automatic logic cla_next_carry(input cla_pg_t grp, input logic ci);
    return grp.g | (grp.p & ci);
  endfunction

endpackage

// File: rtl/cla_block4.sv
// Combinational 4-bit carry-lookahead unit with group propagate/generate terms.
module cla_block4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       pg,
  output logic       gg,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is a flat sum of products of g, p and ci; nothing ripples.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign co = gg | (pg & ci);

  assign s = p ^ c;

endmodule

// File: rtl/cla_adder4.sv
// Registered two-level carry-lookahead adder, WIDTH a positive multiple of 4.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla_adder4
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] z,
  output logic             carry,
`ifdef CLA_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam int unsigned NGroups = cla_groups(WIDTH);

  logic [WIDTH-1:0]   sum;
  logic [NGroups-1:0] pg;
  logic [NGroups-1:0] gg;
  logic [NGroups-1:0] co;
  logic [NGroups:0]   gc;
  cla_pg_t            grp [NGroups];

  assign gc[0] = cin;

  for (genvar k = 0; k < NGroups; k++) begin : g_grp
    cla_block4 u_blk (
      .x  (x[CLA_GROUP_W*k +: CLA_GROUP_W]),
      .y  (y[CLA_GROUP_W*k +: CLA_GROUP_W]),
      .ci (gc[k]),
      .s  (sum[CLA_GROUP_W*k +: CLA_GROUP_W]),
      .pg (pg[k]),
      .gg (gg[k]),
      .co (co[k])
    );
    assign grp[k]   = cla_pg_t'{p: pg[k], g: gg[k]};
    assign gc[k+1]  = cla_next_carry(grp[k], gc[k]);
  end

  // Group carries come from the second-level PG/GG chain; block co is redundant.
  logic unused_co;
  assign unused_co = ^co;

`ifdef CLA_OVF_EN
  logic msb_cin;
  assign msb_cin = sum[WIDTH-1] ^ x[WIDTH-1] ^ y[WIDTH-1];
`endif

  // Loading only under in_valid keeps X on idle inputs out of the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      z         <= '0;
      carry     <= 1'b0;
`ifdef CLA_OVF_EN
      ovf       <= 1'b0;
`endif
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        z     <= sum;
        carry <= gc[NGroups];
`ifdef CLA_OVF_EN
        ovf   <= msb_cin ^ gc[NGroups];
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_adder4.sv
// Self-checking bench: 4-bit and 16-bit instances against an arithmetic reference model.
module tb_cla_adder4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v4, cin4, v16, cin16;
  logic [3:0]  x4, y4, z4;
  logic [15:0] x16, y16, z16;
  logic        c4, c16, vo4, vo16;
`ifdef CLA_OVF_EN
  logic        ovf4, ovf16;
`endif

  cla_adder4 #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v4),
    .x         (x4),
    .y         (y4),
    .cin       (cin4),
    .z         (z4),
    .carry     (c4),
`ifdef CLA_OVF_EN
    .ovf       (ovf4),
`endif
    .out_valid (vo4)
  );

  cla_adder4 #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v16),
    .x         (x16),
    .y         (y16),
    .cin       (cin16),
    .z         (z16),
    .carry     (c16),
`ifdef CLA_OVF_EN
    .ovf       (ovf16),
`endif
    .out_valid (vo16)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what each output register should hold after the next edge.
  logic [3:0]  m4_z;
  logic [15:0] m16_z;
  logic        m4_c, m4_o, m4_v, m16_c, m16_o, m16_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [4:0]  s4;
    logic [16:0] s16;
    if (rst) begin
      m4_z = '0;  m4_c = 1'b0;  m4_o = 1'b0;  m4_v = 1'b0;
      m16_z = '0; m16_c = 1'b0; m16_o = 1'b0; m16_v = 1'b0;
    end else begin
      m4_v  = v4;
      m16_v = v16;
      if (v4) begin
        s4   = 5'(x4) + 5'(y4) + 5'(cin4);
        m4_z = s4[3:0];
        m4_c = s4[4];
        m4_o = (x4[3] == y4[3]) && (s4[3] != x4[3]);
      end
      if (v16) begin
        s16   = 17'(x16) + 17'(y16) + 17'(cin16);
        m16_z = s16[15:0];
        m16_c = s16[16];
        m16_o = (x16[15] == y16[15]) && (s16[15] != x16[15]);
      end
    end
    @(posedge clk);
    #1;
    check("z4",    32'(z4),   32'(m4_z));
    check("cy4",   32'(c4),   32'(m4_c));
    check("vld4",  32'(vo4),  32'(m4_v));
    check("z16",   32'(z16),  32'(m16_z));
    check("cy16",  32'(c16),  32'(m16_c));
    check("vld16", 32'(vo16), 32'(m16_v));
`ifdef CLA_OVF_EN
    check("ovf4",  32'(ovf4),  32'(m4_o));
    check("ovf16", 32'(ovf16), 32'(m16_o));
`endif
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
    v4 = v; x4 = a; y4 = b; cin4 = ci;
  endtask

  logic [3:0] dir_x [10] = '{4'h8, 4'hF, 4'h1, 4'h8, 4'h1, 4'hF, 4'hF, 4'h7, 4'h3, 4'h3};
  logic [3:0] dir_y [10] = '{4'h8, 4'h0, 4'h5, 4'h2, 4'hF, 4'h0, 4'hF, 4'h1, 4'h2, 4'h4};
  logic       dir_c [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    drive4(1'b1, 4'hF, 4'h0, 1'b0);
    v16 = 1'b1; x16 = 16'hFFFF; y16 = 16'h0001; cin16 = 1'b0;

    // Reset dominates in_valid for two cycles.
    cycle();
    cycle();
    rst = 1'b0;
    v16 = 1'b0;

    // Directed vectors back-to-back; the last one (3+4) feeds the hold check.
    for (int i = 0; i < 10; i++) begin
      drive4(1'b1, dir_x[i], dir_y[i], dir_c[i]);
      cycle();
    end
    drive4(1'b0, 4'hF, 4'hF, 1'b0);
    cycle();
    drive4(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
    cycle();
    check("hold_z4", 32'(z4), 32'h7);

    // Reset mid-stream discards the in-flight operand, then restart.
    drive4(1'b1, 4'h5, 4'h5, 1'b0);
    cycle();
    rst = 1'b1;
    drive4(1'b1, 4'h9, 4'h9, 1'b1);
    cycle();
    rst = 1'b0;
    drive4(1'b1, 4'h6, 4'h7, 1'b1);
    cycle();

    // Exhaustive 4-bit sweep alongside random 16-bit traffic.
    for (int i = 0; i < 512; i++) begin
      drive4(1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8));
      v16   = ($urandom_range(0, 7) != 0);
      x16   = 16'($urandom);
      y16   = 16'($urandom);
      cin16 = 1'($urandom);
      cycle();
    end

    // Random valid gaps on both instances, with 16-bit carry-chain corners mixed in.
    for (int i = 0; i < 200; i++) begin
      drive4(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
      v16   = ($urandom_range(0, 3) != 0);
      x16   = (i % 10 == 0) ? 16'hFFFF : 16'($urandom);
      y16   = (i % 10 == 0) ? 16'h0000 : 16'($urandom);
      cin16 = 1'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
